uart_transceiver: RTL and testbench

//  Full-duplex 8N1 UART: independent transmitter (parallel byte -> serial line) and

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_if.sv | 23 ++
 rtl/uart_bit_timer.sv | 27 ++
 rtl/uart_transceiver.sv | 119 +++++++++++
 tb/tb_uart_transceiver.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants and FSM state types for the 8N1 UART
package uart_pkg;

   localparam int DATA_BITS = 8;

   typedef enum logic [2:0] {
      TX_IDLE,
      TX_START,
      TX_DATA,
      TX_STOP,
      TX_DONE
   } tx_state_e;

   typedef enum logic [2:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP,
      RX_CLEANUP
   } rx_state_e;

endpackage

// File: rtl/uart_if.sv
// rtl/uart_if.sv - byte/serial signal bundle between core logic and the UART
interface uart_if;
   import uart_pkg::*;

   logic                 tx_dv;
   logic [DATA_BITS-1:0] tx_byte;
   logic                 tx_active;
   logic                 tx_serial;
   logic                 tx_done;
   logic                 rx_serial;
   logic                 rx_dv;
   logic [DATA_BITS-1:0] rx_byte;

   modport master (
      output tx_dv, tx_byte, rx_serial,
      input  tx_active, tx_serial, tx_done, rx_dv, rx_byte
   );

   modport slave (
      input  tx_dv, tx_byte, rx_serial,
      output tx_active, tx_serial, tx_done, rx_dv, rx_byte
   );
endinterface

// File: rtl/uart_bit_timer.sv
// rtl/uart_bit_timer.sv - per-bit cycle counter with clear and terminal-count flag
module uart_bit_timer #(
   parameter int CLKS_PER_BIT = 217
) (
   input  logic clk,
   input  logic rst_l,
   input  logic clr,
   input  logic half,
   output logic tc
);
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] MID  = CW'((CLKS_PER_BIT - 1) / 2);

   logic [CW-1:0] cnt;

   // half selects the mid-bit point, used to centre the receiver on the start bit
   assign tc = half ? (cnt == MID) : (cnt == LAST);

   always_ff @(posedge clk) begin
      if (!rst_l || clr || tc) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end
endmodule

// File: rtl/uart_transceiver.sv
// rtl/uart_transceiver.sv - full-duplex 8N1 UART, independent TX and RX FSMs
module uart_transceiver
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 217
) (
   input  logic clk,
   input  logic rst_l,
   uart_if.slave bus
);
   localparam int IW = $clog2(DATA_BITS);
   localparam logic [IW-1:0] LAST_BIT = IW'(DATA_BITS - 1);

   tx_state_e            tx_state;
   logic [DATA_BITS-1:0] tx_data;
   logic [IW-1:0]        tx_idx;
   logic                 tx_tc;

   rx_state_e            rx_state;
   logic [DATA_BITS-1:0] rx_shift;
   logic [IW-1:0]        rx_idx;
   logic [1:0]           rx_sync;
   logic                 rx_line;
   logic                 rx_tc;

   uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx_timer (
      .clk   (clk),
      .rst_l (rst_l),
      .clr   ((tx_state == TX_IDLE) || (tx_state == TX_DONE)),
      .half  (1'b0),
      .tc    (tx_tc)
   );

   uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx_timer (
      .clk   (clk),
      .rst_l (rst_l),
      .clr   ((rx_state == RX_IDLE) || (rx_state == RX_CLEANUP)),
      .half  (rx_state == RX_START),
      .tc    (rx_tc)
   );

   always_ff @(posedge clk) begin
      if (!rst_l) begin
         tx_state <= TX_IDLE;
         tx_data  <= '0;
         tx_idx   <= '0;
      end else begin
         case (tx_state)
            TX_IDLE: if (bus.tx_dv) begin
               tx_data  <= bus.tx_byte;
               tx_state <= TX_START;
            end
            TX_START: if (tx_tc) begin
               tx_idx   <= '0;
               tx_state <= TX_DATA;
            end
            TX_DATA: if (tx_tc) begin
               if (tx_idx == LAST_BIT) tx_state <= TX_STOP;
               else                    tx_idx   <= tx_idx + 1'b1;
            end
            TX_STOP: if (tx_tc) tx_state <= TX_DONE;
            default: tx_state <= TX_IDLE;
         endcase
      end
   end

   // line decoded from state so a reset returns it high on the very next cycle
   always_comb begin
      bus.tx_serial = 1'b1;
      case (tx_state)
         TX_START: bus.tx_serial = 1'b0;
         TX_DATA:  bus.tx_serial = tx_data[tx_idx];
         default:  bus.tx_serial = 1'b1;
      endcase
   end

   assign bus.tx_active = (tx_state == TX_START) || (tx_state == TX_DATA) || (tx_state == TX_STOP);
   assign bus.tx_done   = (tx_state == TX_DONE);

   always_ff @(posedge clk) begin
      if (!rst_l) rx_sync <= 2'b11;
      else        rx_sync <= {rx_sync[0], bus.rx_serial};
   end

   assign rx_line = rx_sync[1];

   always_ff @(posedge clk) begin
      if (!rst_l) begin
         rx_state    <= RX_IDLE;
         rx_shift    <= '0;
         rx_idx      <= '0;
         bus.rx_dv   <= 1'b0;
         bus.rx_byte <= '0;
      end else begin
         bus.rx_dv <= 1'b0;
         case (rx_state)
            RX_IDLE: if (!rx_line) rx_state <= RX_START;
            RX_START: if (rx_tc) begin
               rx_idx   <= '0;
               rx_state <= rx_line ? RX_IDLE : RX_DATA;
            end
            RX_DATA: if (rx_tc) begin
               rx_shift[rx_idx] <= rx_line;
               if (rx_idx == LAST_BIT) rx_state <= RX_STOP;
               else                    rx_idx   <= rx_idx + 1'b1;
            end
            RX_STOP: if (rx_tc) begin
               // a low stop bit is a framing error: the byte is dropped silently
               if (rx_line) begin
                  bus.rx_byte <= rx_shift;
                  bus.rx_dv   <= 1'b1;
               end
               rx_state <= RX_CLEANUP;
            end
            default: rx_state <= RX_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_uart_transceiver.sv
// tb/tb_uart_transceiver.sv - self-checking bench for uart_transceiver with a frame-level model
module tb_uart_transceiver;
   localparam int CPB   = 217;
   localparam int FRAME = 10 * CPB;

   logic clk = 1'b0;
   logic rst_l = 1'b0;
   logic loop_en = 1'b1;
   logic man_line = 1'b1;

   uart_if bus();

   assign bus.rx_serial = loop_en ? (bus.tx_active ? bus.tx_serial : 1'b1) : man_line;

   uart_transceiver #(.CLKS_PER_BIT(CPB)) dut (
      .clk   (clk),
      .rst_l (rst_l),
      .bus   (bus)
   );

   always #20 clk = ~clk;

   int         total = 0;
   int         bad = 0;
   bit         chk_en = 0;
   int         tx_m = -1;
   logic [9:0] tx_frame = '0;
   logic [7:0] rx_q[$];
   logic [7:0] rx_last = 8'h00;
   int         dv_cnt = 0;
   logic [7:0] dv_byte = 8'h00;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   // one clock: advance the frame model at the edge, compare outputs at the falling edge
   task automatic tick();
      logic el, ea, ed;
      @(posedge clk);
      if (!rst_l) begin
         tx_m = -1;
         rx_q.delete();
         rx_last = 8'h00;
      end else if (tx_m < 0) begin
         if (bus.tx_dv) begin
            tx_m = 0;
            tx_frame = {1'b1, bus.tx_byte, 1'b0};
            if (loop_en) rx_q.push_back(bus.tx_byte);
         end
      end else begin
         tx_m++;
         if (tx_m > FRAME) tx_m = -1;
      end
      @(negedge clk);
      if (bus.rx_dv) begin
         dv_cnt++;
         dv_byte = bus.rx_byte;
      end
      if (chk_en) begin
         if (tx_m < 0) begin
            el = 1'b1; ea = 1'b0; ed = 1'b0;
         end else if (tx_m < FRAME) begin
            el = tx_frame[tx_m / CPB]; ea = 1'b1; ed = 1'b0;
         end else begin
            el = 1'b1; ea = 1'b0; ed = 1'b1;
         end
         check("tx_serial", bus.tx_serial, el);
         check("tx_active", bus.tx_active, ea);
         check("tx_done", bus.tx_done, ed);
         if (bus.rx_dv) begin
            if (rx_q.size() == 0) begin
               check("rx_dv_unexpected", bus.rx_dv, 1'b0);
            end else begin
               rx_last = rx_q.pop_front();
               check("rx_byte_new", bus.rx_byte, rx_last);
            end
         end else begin
            check("rx_byte_hold", bus.rx_byte, rx_last);
         end
      end
   endtask

   task automatic ticks(input int n);
      repeat (n) tick();
   endtask

   // strobe a byte, optionally strobe 8'hAA again at tick inj_n, run until tx_done
   task automatic send_wait(input logic [7:0] b, input int inj_n, output int n, output logic [9:0] mids);
      bus.tx_byte = b;
      bus.tx_dv = 1'b1;
      tick();
      bus.tx_dv = 1'b0;
      n = 0;
      mids = '0;
      while (!bus.tx_done && n < FRAME + 50) begin
         bus.tx_dv = (n == inj_n);
         if (bus.tx_dv) bus.tx_byte = 8'hAA;
         tick();
         n++;
         if (n % CPB == CPB / 2 && n / CPB < 10) mids[n / CPB] = bus.tx_serial;
      end
      bus.tx_dv = 1'b0;
   endtask

   task automatic send_manual(input logic [7:0] b, input logic stop);
      logic [9:0] f;
      f = {stop, b, 1'b0};
      if (stop) rx_q.push_back(b);
      for (int i = 0; i < 10; i++) begin
         man_line = f[i];
         ticks(CPB);
      end
      man_line = 1'b1;
      ticks(20);
   endtask

   initial begin
      int         n;
      int         d0;
      logic [9:0] mids;

      bus.tx_dv = 1'b0;
      bus.tx_byte = 8'h00;
      ticks(3);
      check("rst_tx_serial", bus.tx_serial, 1'b1);
      check("rst_tx_active", bus.tx_active, 1'b0);
      check("rst_tx_done", bus.tx_done, 1'b0);
      check("rst_rx_dv", bus.rx_dv, 1'b0);
      check("rst_rx_byte", bus.rx_byte, 8'h00);
      chk_en = 1;
      rst_l = 1'b1;
      ticks(10);

      d0 = dv_cnt;
      send_wait(8'h3F, -1, n, mids);
      check("t1_done_latency", n, FRAME);
      check("t1_rx_dv_count", dv_cnt - d0, 1);
      check("t1_rx_byte", dv_byte, 8'h3F);
      ticks(5);

      send_wait(8'hA5, -1, n, mids);
      check("t2_line_bits", mids, 10'b1101001010);
      check("t2_rx_byte", dv_byte, 8'hA5);
      ticks(5);

      d0 = dv_cnt;
      send_wait(8'h00, 1000, n, mids);
      check("t3_first_byte", dv_byte, 8'h00);
      bus.tx_byte = 8'h77;
      bus.tx_dv = 1'b1;
      tick();
      send_wait(8'hFF, -1, n, mids);
      check("t3_second_byte", dv_byte, 8'hFF);
      check("t3_rx_dv_count", dv_cnt - d0, 2);
      ticks(5);

      loop_en = 1'b0;
      d0 = dv_cnt;
      man_line = 1'b0;
      ticks(50);
      man_line = 1'b1;
      ticks(300);
      check("t4_glitch_no_dv", dv_cnt - d0, 0);
      send_manual(8'h55, 1'b1);
      check("t4_rx_dv_count", dv_cnt - d0, 1);
      check("t4_rx_byte", bus.rx_byte, 8'h55);

      d0 = dv_cnt;
      send_manual(8'h12, 1'b0);
      ticks(300);
      check("t5_framing_no_dv", dv_cnt - d0, 0);
      check("t5_byte_kept", bus.rx_byte, 8'h55);

      loop_en = 1'b1;
      bus.tx_byte = 8'h99;
      bus.tx_dv = 1'b1;
      tick();
      bus.tx_dv = 1'b0;
      ticks(800);
      rst_l = 1'b0;
      tick();
      check("t6_rst_tx_serial", bus.tx_serial, 1'b1);
      check("t6_rst_tx_active", bus.tx_active, 1'b0);
      check("t6_rst_rx_byte", bus.rx_byte, 8'h00);
      rst_l = 1'b1;
      ticks(5);
      d0 = dv_cnt;
      send_wait(8'h3C, -1, n, mids);
      check("t6_rx_dv_count", dv_cnt - d0, 1);
      check("t6_rx_byte", bus.rx_byte, 8'h3C);
      ticks(10);
      check("queue_drained", rx_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
